mem_stage_hs: RTL
=================

MEM_STAGE_HS -- requirements
Module: mem_stage_hs

Interface
REQ-001 Parameter ADDR_W, default 32: data-memory byte-address width.
REQ-002 Parameter TIMEOUT, default 15: maximum wait cycles for dm_ready before abort; range 1..255.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid, mem_wr, mem_to_reg, reg_wr, loadext  in  1 each  EX-stage valid and controls; loadext=1 selects sign extension, 0 selects zero extension.
REQ-006 dsize  in  2  access size: 00 byte, 01 half, 11 word, 10 reserved.
REQ-007 exec_result  in  ADDR_W  ALU result / byte address; busb  in  32  store data; rw  in  5  destination register.
REQ-008 flush  in  1  kills the instruction presented this cycle.
REQ-009 stall  out  1  EX must hold its inputs while high.
REQ-010 dm_req, dm_we  out  1 each; dm_addr  out  ADDR_W (word-aligned); dm_wdata  out  32; dm_be  out  4  byte-lane enables.
REQ-011 dm_ready  in  1; dm_rdata  in  32  valid when dm_ready=1.
REQ-012 wb_valid, wb_regwr, wb_memtoreg  out  1 each; wb_rw  out  5; wb_data  out  32  loaded value; wb_exec  out  ADDR_W  exec_result passthrough.
REQ-013 misalign_err, timeout_err  out  1 each  single-cycle error pulses.

Function
REQ-014 FSM states IDLE, BUSY, DONE; "accept" = IDLE & in_valid & !flush.
REQ-015 Accepted non-memory op (mem_wr=0, mem_to_reg=0): next cycle wb_valid=1 with inputs registered; latency 1; no dm_req; stays IDLE.
REQ-016 Accepted memory op, aligned: go to BUSY and, from the next cycle, drive dm_req=1, dm_we=mem_wr, dm_addr = exec_result with bits [1:0] cleared; hold all dm_* stable until dm_ready.
REQ-017 Alignment: half requires addr[0]=0; word requires addr[1:0]=00; dsize=10 is always misaligned.
REQ-018 Misaligned memory op: no dm_req; next cycle wb_valid=1, wb_regwr=0, misalign_err=1 for one cycle; FSM stays IDLE.
REQ-019 Store lanes: byte -> dm_be = 0001 shifted left by addr[1:0], busb[7:0] replicated on all four lanes; half -> 0011 (addr[1]=0) or 1100 (addr[1]=1), busb[15:0] on both halves; word -> 1111, busb unchanged. Loads drive dm_be=1111.
REQ-020 Load: on dm_ready in BUSY, select byte dm_rdata[8*addr[1:0]+:8] or half dm_rdata[16*addr[1]+:16], then extend per loadext; word unchanged; register into wb_data.
REQ-021 BUSY & dm_ready: go to DONE; in DONE wb_valid=1 for exactly one cycle, then IDLE. Store completion also produces wb_valid with wb_regwr as latched.
REQ-022 stall=1 in BUSY, and in IDLE when in_valid & !flush & aligned memory op; stall=0 in DONE and otherwise.
REQ-023 Wait counter clears on entry to BUSY and increments each BUSY cycle without dm_ready; upon reaching TIMEOUT: dm_req drops, timeout_err=1 for one cycle, wb_valid=1 with wb_regwr=0, return to IDLE.
REQ-024 dm_ready in the same cycle the counter reaches TIMEOUT counts as success; no error.
REQ-025 flush while BUSY is ignored; the in-flight access completes. flush with in_valid in IDLE: nothing accepted, wb_valid=0 next cycle.
REQ-026 dm_ready outside BUSY is ignored.
REQ-027 wb_valid=0 on every cycle in which no completion, error or passthrough occurs; wb_* data fields hold their last values.

Reset
REQ-028 reset=1 at a clock edge: FSM to IDLE, wait counter 0, all outputs 0 (stall, dm_req, dm_we, dm_be, wb_*, error pulses), data registers 0.
REQ-029 Reset during BUSY aborts the access: dm_req=0 from the next cycle; no wb_valid and no error pulse.

Verification
REQ-030 ALU op: exec_result=0x1234, reg_wr=1, rw=7 -> one cycle later wb_valid=1, wb_exec=0x1234, wb_rw=7, no dm_req.
REQ-031 Byte load, addr=0x103, loadext=1, dm_ready after 3 cycles with dm_rdata=0x80FF_FF00 -> dm_addr=0x100, wb_data=0xFFFF_FF80, stall high 4 cycles.
REQ-032 Half store, addr=0x202, busb=0x0000_ABCD -> dm_be=1100, dm_wdata=0xABCD_ABCD, dm_we=1, then wb_valid.
REQ-033 Word load, addr=0x101 -> no dm_req, misalign_err=1 for 1 cycle, wb_regwr=0.
REQ-034 Load with dm_ready held low, TIMEOUT=15 -> after 15 BUSY cycles timeout_err=1, dm_req=0, FSM back in IDLE.
REQ-035 reset asserted on the 2nd BUSY cycle -> dm_req=0 the next cycle, wb_valid stays 0, a subsequent op behaves normally.

Source files
------------

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: MEM pipeline stage with data-memory handshake, alignment checks, lane steering and wait timeout
module mem_stage_hs #(
  parameter int ADDR_W = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              mem_wr,
  input  logic              mem_to_reg,
  input  logic              reg_wr,
  input  logic              loadext,
  input  logic [1:0]        dsize,
  input  logic [ADDR_W-1:0] exec_result,
  input  logic [31:0]       busb,
  input  logic [4:0]        rw,
  input  logic              flush,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic [3:0]        dm_be,
  input  logic              dm_ready,
  input  logic [31:0]       dm_rdata,
  output logic              wb_valid,
  output logic              wb_regwr,
  output logic              wb_memtoreg,
  output logic [4:0]        wb_rw,
  output logic [31:0]       wb_data,
  output logic [ADDR_W-1:0] wb_exec,
  output logic              misalign_err,
  output logic              timeout_err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] cnt;
  logic mem_op, aligned, accept, go_busy, misal, timeout;
  logic [3:0] be;
  logic [31:0] wdata, ld_data;
  logic [7:0] b_sel;
  logic [15:0] h_sel;
  logic [1:0] l_size, l_off;
  logic l_ext, l_regwr, l_memtoreg;
  logic [4:0] l_rw;
  logic [ADDR_W-1:0] l_exec;
  always_comb begin
    mem_op = mem_wr | mem_to_reg;
    aligned = dsize == 2'b00 | (dsize == 2'b01 & !exec_result[0]) | (dsize == 2'b11 & exec_result[1:0] == 2'b00);
    accept = state == IDLE & in_valid & !flush;
    go_busy = accept & mem_op & aligned;
    misal = accept & mem_op & !aligned;
    timeout = state == BUSY & !dm_ready & cnt == 8'(TIMEOUT - 1);
    stall = state == BUSY | go_busy;
    state_nx = go_busy ? BUSY : state == BUSY ? (dm_ready ? DONE : timeout ? IDLE : BUSY) : IDLE;
    be = !mem_wr ? 4'b1111 : dsize == 2'b00 ? 4'b0001 << exec_result[1:0] : dsize == 2'b01 ? (exec_result[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = dsize == 2'b00 ? {4{busb[7:0]}} : dsize == 2'b01 ? {2{busb[15:0]}} : busb;
    b_sel = 8'(dm_rdata >> {l_off, 3'b000});
    h_sel = l_off[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    ld_data = l_size == 2'b00 ? {{24{l_ext & b_sel[7]}}, b_sel} : l_size == 2'b01 ? {{16{l_ext & h_sel[15]}}, h_sel} : dm_rdata;
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      dm_req <= 1'b0;
      dm_we <= 1'b0;
      dm_addr <= '0;
      dm_wdata <= '0;
      dm_be <= '0;
      wb_valid <= 1'b0;
      wb_regwr <= 1'b0;
      wb_memtoreg <= 1'b0;
      wb_rw <= '0;
      wb_data <= '0;
      wb_exec <= '0;
      misalign_err <= 1'b0;
      timeout_err <= 1'b0;
      l_size <= '0;
      l_off <= '0;
      l_ext <= 1'b0;
      l_regwr <= 1'b0;
      l_memtoreg <= 1'b0;
      l_rw <= '0;
      l_exec <= '0;
    end else begin
      wb_valid <= 1'b0;
      misalign_err <= 1'b0;
      timeout_err <= 1'b0;
      if (accept & !go_busy) begin
        wb_valid <= 1'b1;
        wb_regwr <= reg_wr & !misal;
        wb_memtoreg <= mem_to_reg;
        wb_rw <= rw;
        wb_exec <= exec_result;
        misalign_err <= misal;
      end
      if (go_busy) begin
        cnt <= '0;
        dm_req <= 1'b1;
        dm_we <= mem_wr;
        dm_addr <= {exec_result[ADDR_W-1:2], 2'b00};
        dm_be <= be;
        dm_wdata <= wdata;
        l_size <= dsize;
        l_off <= exec_result[1:0];
        l_ext <= loadext;
        l_regwr <= reg_wr;
        l_memtoreg <= mem_to_reg;
        l_rw <= rw;
        l_exec <= exec_result;
      end
      if (state == BUSY) begin
        if (dm_ready | timeout) begin
          dm_req <= 1'b0;
          wb_valid <= 1'b1;
          wb_regwr <= l_regwr & dm_ready;
          wb_memtoreg <= l_memtoreg;
          wb_rw <= l_rw;
          wb_exec <= l_exec;
          timeout_err <= timeout;
        end else
          cnt <= cnt + 8'd1;
        if (dm_ready & !dm_we)
          wb_data <= ld_data;
      end
    end
  end
endmodule
